// File: rtl/key_event_buf.sv
// Keypad receiver: syncs and debounces {key_in,key_val}, queues one key code per debounced press.
// Latency: push (rd_valid) after edge 3+DEBOUNCE_CYCLES from a stable input; rd_data is show-ahead.
// Backpressure: reader pops with rd_ack; a press arriving at a full FIFO with no pop is dropped and sets sticky overflow.
module key_event_buf #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_in,
    input  logic [3:0] i_key_val,
    input  logic       i_rd_ack,
    input  logic       i_clr_ovf,
    output logic       o_rd_valid,
    output logic [3:0] o_rd_data,
    output logic       o_key_held,
    output logic       o_overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_RELEASE_WAIT
    } state_t;

    logic [4:0]    r_s1, r_s2;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cap;
    logic          r_key_held;
    logic          w_cnt_inc, w_push, w_cap_ld;
    logic          w_s2_key;
    logic [3:0]    w_s2_val;

    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [PW:0]   r_count;
    logic          r_overflow;
    logic          w_full, w_pop, w_wr, w_drop;

    assign w_s2_key = r_s2[4];
    assign w_s2_val = r_s2[3:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {i_key_in, i_key_val};
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_inc = 1'b0;
        w_push    = 1'b0;
        w_cap_ld  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_s2_key) begin
                    w_next   = S_PRESS_WAIT;
                    w_cap_ld = 1'b1;
                end
            end
            S_PRESS_WAIT: begin
                // Any change of the code during the wait is treated as a glitch.
                if (!w_s2_key || (w_s2_val != r_cap)) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = S_HELD;
                    w_push = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_HELD: begin
                if (!w_s2_key) w_next = S_RELEASE_WAIT;
            end
            S_RELEASE_WAIT: begin
                if (w_s2_key) begin
                    w_next = S_HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cap      <= '0;
            r_key_held <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_key_held <= (w_next == S_HELD) || (w_next == S_RELEASE_WAIT);
            if (w_next != r_state) r_cnt <= '0;
            else if (w_cnt_inc)    r_cnt <= r_cnt + CW'(1);
            if (w_cap_ld) r_cap <= w_s2_val;
        end
    end

    assign o_key_held = r_key_held;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_full = (r_count == CNT_FULL);
    assign w_pop  = i_rd_ack & o_rd_valid;
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_cap;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)         r_overflow <= 1'b1;
            else if (i_clr_ovf) r_overflow <= 1'b0;
        end
    end

    assign o_rd_valid = (r_count != '0);
    assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : 4'd0;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_key_event_buf.sv
// Directed bench for key_event_buf with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_key_event_buf;

    logic       clk;
    logic       rst_n;
    logic       key_in;
    logic [3:0] key_val;
    logic       rd_ack;
    logic       clr_ovf;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic       key_held;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;
    logic min_held;
    logic max_seen;

    key_event_buf #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_key_in   (key_in),
        .i_key_val  (key_val),
        .i_rd_ack   (rd_ack),
        .i_clr_ovf  (clr_ovf),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_key_held (key_held),
        .o_overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Debounced press of code v: held 10 cycles, released 10 cycles (back in IDLE).
    task automatic press(input logic [3:0] v);
        key_in  = 1'b1;
        key_val = v;
        step(10);
        key_in  = 1'b0;
        step(10);
    endtask

    task automatic ack_once;
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        key_in  = 1'b0;
        key_val = 4'd0;
        rd_ack  = 1'b0;
        clr_ovf = 1'b0;
        step(3);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        chk("rst_key_held", 32'(key_held), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step(2);

        // 1: clean press of 9, held 20 cycles
        key_in  = 1'b1;
        key_val = 4'd9;
        step(6);
        chk("t1_valid_edge6", 32'(rd_valid), 32'd0);
        chk("t1_held_edge6",  32'(key_held), 32'd0);
        step(1);
        chk("t1_valid_edge7", 32'(rd_valid), 32'd1);
        chk("t1_data_edge7",  32'(rd_data),  32'd9);
        chk("t1_held_edge7",  32'(key_held), 32'd1);
        step(13);
        key_in = 1'b0;
        step(10);
        chk("t1_held_released", 32'(key_held), 32'd0);
        chk("t1_data_before_ack", 32'(rd_data), 32'd9);
        ack_once();
        chk("t1_single_event", 32'(rd_valid), 32'd0);
        chk("t1_empty_data",   32'(rd_data),  32'd0);

        // 2: 3-cycle glitch produces nothing
        key_in  = 1'b1;
        key_val = 4'd3;
        max_seen = 1'b0;
        step(3);
        key_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            max_seen = max_seen | key_held | rd_valid;
        end
        chk("t2_no_event_or_held", 32'(max_seen), 32'd0);
        chk("t2_rd_valid", 32'(rd_valid), 32'd0);

        // 3: press 5 with a 2-cycle bounce while held
        key_in  = 1'b1;
        key_val = 4'd5;
        step(10);
        chk("t3_held_before_bounce", 32'(key_held), 32'd1);
        min_held = 1'b1;
        key_in = 1'b0;
        step(2);
        key_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            min_held = min_held & key_held;
            step(1);
        end
        chk("t3_held_through_bounce", 32'(min_held), 32'd1);
        key_in = 1'b0;
        step(10);
        chk("t3_data", 32'(rd_data), 32'd5);
        ack_once();
        chk("t3_single_event", 32'(rd_valid), 32'd0);

        // 4: five presses into a 4-deep FIFO
        for (int k = 1; k <= 5; k++) press(4'(k));
        chk("t4_overflow_set", 32'(overflow), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t4_read%0d", k), 32'(rd_data), 32'(k));
            ack_once();
        end
        chk("t4_drained", 32'(rd_valid), 32'd0);
        chk("t4_overflow_still", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("t4_overflow_clr", 32'(overflow), 32'd0);

        // 5: full FIFO, pop coincides with push of 7
        press(4'hA);
        press(4'hB);
        press(4'hC);
        press(4'hD);
        chk("t5_head_a", 32'(rd_data), 32'hA);
        key_in  = 1'b1;
        key_val = 4'd7;
        step(6);
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
        chk("t5_no_overflow", 32'(overflow), 32'd0);
        step(3);
        key_in = 1'b0;
        step(10);
        chk("t5_read1", 32'(rd_data), 32'hB);
        ack_once();
        chk("t5_read2", 32'(rd_data), 32'hC);
        ack_once();
        chk("t5_read3", 32'(rd_data), 32'hD);
        ack_once();
        chk("t5_read4", 32'(rd_data), 32'h7);
        ack_once();
        chk("t5_drained", 32'(rd_valid), 32'd0);
        chk("t5_overflow_final", 32'(overflow), 32'd0);

        // 6: async reset mid-PRESS_WAIT with queued events and overflow set
        for (int k = 1; k <= 5; k++) press(4'(k));
        ack_once();
        ack_once();
        chk("t6_pre_valid", 32'(rd_valid), 32'd1);
        chk("t6_pre_data",  32'(rd_data),  32'd3);
        chk("t6_pre_ovf",   32'(overflow), 32'd1);
        key_in  = 1'b1;
        key_val = 4'd6;
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(rd_valid), 32'd0);
        chk("t6_async_ovf",   32'(overflow), 32'd0);
        chk("t6_async_data",  32'(rd_data),  32'd0);
        chk("t6_async_held",  32'(key_held), 32'd0);
        key_in = 1'b0;
        step(2);
        rst_n = 1'b1;
        max_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            max_seen = max_seen | rd_valid | key_held;
        end
        chk("t6_no_event_after_reset", 32'(max_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
